cuila_trace_tx: RTL

Transmit end of the CUILA debug probe path. Captures one trace record per valid decoded instruction (instruction word, ALU result, ALU status) into a small FIFO. Emits each record as a fixed 11-byte framed packet on a UART 8N1 serial line for the host-side analyser. Sits beside the core's decoder/ALU probe taps, on the core clock.

---
 rtl/cuila_trace_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cuila_trace_tx.sv
// CUILA trace transmitter: captures decoder/ALU probe records into a FIFO and
// serialises each one as an 11-byte framed packet on a UART 8N1 line.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a queued record
// LOAD   | pop head record, latch packet fields and checksum
// START  | start bit (line low) for one bit time
// DATA   | eight data bits, LSB first
// STOP   | stop bit (line high); next byte or back to IDLE
module cuila_trace_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        capture_en,
    input  logic                        decoder_inst_valid,
    input  logic [31:0]                 decoder_inst_payload,
    input  logic [31:0]                 alu_res,
    input  logic                        alu_status_negative,
    input  logic                        alu_status_zero,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] BIT_TOP    = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    SYNC_BYTE  = 8'hA5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // record layout: {neg, zero, seq[4:0], payload[31:0], alu_res[31:0]}
    logic [70:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [70:0]   head;
    logic [4:0]    seq;
    logic          pending_drop;
    logic          push_req, pop, fifo_full, push_ok, drop;

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [3:0]    byte_idx;
    logic [7:0]    flags_r, csum_r;
    logic [31:0]   payload_r, alu_r;
    logic [7:0]    load_flags, load_csum, cur_byte;

    assign push_req  = capture_en & decoder_inst_valid;
    assign pop       = (state == S_LOAD);
    assign fifo_full = (fifo_level == FULL_LEVEL);
    // A full FIFO still accepts a push on the edge that pops the head.
    assign push_ok   = push_req & (~fifo_full | pop);
    assign drop      = push_req & ~push_ok;
    assign head      = mem[rd_ptr];
    assign busy      = (state != S_IDLE);

    // Record storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {alu_status_negative, alu_status_zero, seq,
                            decoder_inst_payload, alu_res};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push_ok)
                fifo_level <= fifo_level - 1'b1;
        end
    end

    // Sequence number, saturating drop counter and the drop flag for the next packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seq          <= '0;
            drop_count   <= '0;
            pending_drop <= 1'b0;
        end else begin
            if (push_ok)
                seq <= seq + 5'd1;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            // A drop on the LOAD edge wins so it is reported in the following packet.
            if (drop)
                pending_drop <= 1'b1;
            else if (pop)
                pending_drop <= 1'b0;
        end
    end

    // Packet fields derived from the head record at LOAD.
    always_comb begin
        load_flags = {head[70], head[69], pending_drop, head[68:64]};
        load_csum  = load_flags;
        for (int k = 0; k < 4; k++) begin
            load_csum = load_csum ^ head[32 + 8*k +: 8] ^ head[8*k +: 8];
        end
    end

    // Byte currently on the wire, selected by position in the packet.
    always_comb begin
        case (byte_idx)
            4'd0:    cur_byte = SYNC_BYTE;
            4'd1:    cur_byte = flags_r;
            4'd2:    cur_byte = payload_r[7:0];
            4'd3:    cur_byte = payload_r[15:8];
            4'd4:    cur_byte = payload_r[23:16];
            4'd5:    cur_byte = payload_r[31:24];
            4'd6:    cur_byte = alu_r[7:0];
            4'd7:    cur_byte = alu_r[15:8];
            4'd8:    cur_byte = alu_r[23:16];
            4'd9:    cur_byte = alu_r[31:24];
            default: cur_byte = csum_r;
        endcase
    end

    // Line driver: decoded from state so reset forces the line high at once.
    always_comb begin
        tx = 1'b1;
        if (state == S_START)
            tx = 1'b0;
        else if (state == S_DATA)
            tx = cur_byte[bit_idx];
    end

    // Framing FSM with a down-counting bit timer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            flags_r   <= '0;
            csum_r    <= '0;
            payload_r <= '0;
            alu_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_level != '0)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    flags_r   <= load_flags;
                    csum_r    <= load_csum;
                    payload_r <= head[63:32];
                    alu_r     <= head[31:0];
                    byte_idx  <= '0;
                    timer     <= BIT_TOP;
                    state     <= S_START;
                end
                S_START: begin
                    if (timer == '0) begin
                        timer   <= BIT_TOP;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (timer == '0) begin
                        timer <= BIT_TOP;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_STOP: begin
                    if (timer == '0) begin
                        if (byte_idx < 4'd10) begin
                            byte_idx <= byte_idx + 4'd1;
                            timer    <= BIT_TOP;
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
